texture_mapper_dual_port_fifo_ram: RTL and testbench
====================================================

Name: texture_mapper_dual_port_fifo_ram

Overview:
- Generic true dual-port memory that serves as the storage array behind the texture_mapper FWFT FIFOs.
- A single parameterised block covers two uses:
  - latency=0: LUT-RAM style, combinational read.
  - latency=1: block-RAM style, registered read.
- The FIFO logic drives port A as the write side and port B as the read side; both ports are fully capable.

Parameters:
- width_a, 32, port A data width in bits.
- width_b, 32, port B data width; must equal width_a, else the sim elaboration check fails.
- widthad_a, 4, port A address width.
- widthad_b, 4, port B address width; must equal widthad_a.
- numwords_a, 16, number of words; legal range 1..2**widthad_a.
- numwords_b, 16, must equal numwords_a.
- latency, 1, read latency in cycles; legal values 0, 1, 2.
- ramstyle, "", synthesis hint string ("block", "distributed", "registers", ""); passed as an attribute only, no functional effect.

Ports:
- clk  in  1  single clock; all writes and output registers use the rising edge.
- reset  in  1  asynchronous, active-low (asserted at 0); clears output registers only.
- clken  in  1  clock enable; 0 blocks writes and freezes output registers.
- address_a  in  widthad_a  port A address.
- wren_a  in  1  port A write enable.
- data_a  in  width_a  port A write data.
- q_a  out  width_a  port A read data.
- address_b  in  widthad_b  port B address.
- wren_b  in  1  port B write enable.
- data_b  in  width_b  port B write data.
- q_b  out  width_b  port B read data.

Behaviour:
- Storage is numwords_a x width_a. Contents are not affected by reset and are X/undefined at power-up.
- Write: at a rising clk with clken=1 and wren_x=1 and address_x<numwords, mem[address_x] <= data_x.
  - Addresses >= numwords are ignored for writes; reads of them return 0.
- Dual write collision (both ports write the same address in the same cycle): port A data wins.
- latency=0:
  - q_x = mem[address_x] combinationally.
  - A write becomes visible on q after the clock edge that performs it.
  - reset and clken have no effect on q.
- latency=1:
  - At a rising edge with clken=1, q_x <= mem[address_x], sampled before that edge's write (read-first, both same-port and cross-port).
  - Data written at edge N is readable at edge N+1 and appears on q at N+1.
- latency=2: one additional output register after the latency=1 register. It uses the same clken and reset rules.
- clken=0: no memory write; all output registers hold their values.
- reset=0 (any time, asynchronous): all output registers clear to 0 immediately and hold 0 while asserted.
  - The memory array is untouched; a mid-operation reset never corrupts stored data.
  - Writes presented while reset=0 are still performed if clken=1 (reset gates outputs only).
- Reset deassertion is synchronised externally; the first rising edge with reset=1 behaves as a normal cycle.
- The FIFO wrapper's only requirement: a word written at edge N is readable at the same address on port B from edge N+1 onward.

Optional Feature:
- Macro TEXTURE_MAPPER_RAM_COLLISION_CHECK_EN.
- Defined: a simulation-only checker (excluded from synthesis) runs on every rising edge with clken=1 and wren_a=1 and wren_b=1 and address_a==address_b.
  - It prints "Error: dual-port write collision at address <n>" and calls $finish.
  - It also checks the parameter-equality constraints at time 0.
- Undefined: no checker is compiled; collisions resolve silently with port A winning. Hardware is identical either way.

Test Plan:
- latency=1, reset pulse low: q_a=q_b=0 asynchronously, without waiting for a clk edge. Then write 0xDEADBEEF to addr 3 via A, read addr 3 via B next cycle -> q_b=0xDEADBEEF one cycle after the address is presented.
- latency=1, same-cycle write A addr 5 = 0x11 and read B addr 5 (old contents 0x22): q_b=0x22 that edge, 0x11 the following edge.
- latency=0: write addr 7 = 0xA5A5 -> q_b (address_b=7) changes combinationally to 0xA5A5 right after the edge; toggling reset has no effect on q_b.
- clken=0 with wren_a=1 addr 2 = 0x99: memory is unchanged (a later read returns the prior value) and q_b holds its value across 3 cycles.
- Both ports write addr 9 (A=0x1, B=0x2): a later read returns 0x1. With TEXTURE_MAPPER_RAM_COLLISION_CHECK_EN the sim stops with the error message.
- depth=16 wrap: write addrs 0..15 sequentially, then read back 0..15 via B -> data in order with no loss; a reset asserted mid-sequence preserves all stored words.

Source files
------------

// File: rtl/texture_mapper_dual_port_fifo_ram.sv
// True dual-port RAM behind the texture_mapper FWFT FIFOs; read latency 0, 1 or 2 cycles.
// Define TEXTURE_MAPPER_RAM_COLLISION_CHECK_EN for a simulation-only write-collision/parameter checker.
module texture_mapper_dual_port_fifo_ram #(
    parameter int    width_a    = 32,
    parameter int    width_b    = 32,
    parameter int    widthad_a  = 4,
    parameter int    widthad_b  = 4,
    parameter int    numwords_a = 16,
    parameter int    numwords_b = 16,
    parameter int    latency    = 1,
    parameter string ramstyle   = ""
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clken,
    input  logic [widthad_a-1:0] address_a,
    input  logic                 wren_a,
    input  logic [width_a-1:0]   data_a,
    output logic [width_a-1:0]   q_a,
    input  logic [widthad_b-1:0] address_b,
    input  logic                 wren_b,
    input  logic [width_b-1:0]   data_b,
    output logic [width_b-1:0]   q_b
);

    // The style hint is only a synthesis attribute; it has no functional effect.
    localparam bit unused_ramstyle_blank = (ramstyle == "");

    (* ramstyle = ramstyle *) logic [width_a-1:0] r_mem [numwords_a];

    logic                 w_a_in_range;
    logic                 w_b_in_range;
    logic [width_a-1:0]   w_rd_a;
    logic [width_b-1:0]   w_rd_b;

    function automatic logic f_in_range_a(input logic [widthad_a-1:0] i_addr);
        return 32'(i_addr) < 32'(numwords_a);
    endfunction

    function automatic logic f_in_range_b(input logic [widthad_b-1:0] i_addr);
        return 32'(i_addr) < 32'(numwords_b);
    endfunction

    assign w_a_in_range = f_in_range_a(address_a);
    assign w_b_in_range = f_in_range_b(address_b);

    // Port A is written last so it wins when both ports hit the same word.
    always_ff @(posedge clk) begin
        if (clken) begin
            if (wren_b && w_b_in_range) begin
                r_mem[address_b] <= data_b;
            end
            if (wren_a && w_a_in_range) begin
                r_mem[address_a] <= data_a;
            end
        end
    end

    assign w_rd_a = w_a_in_range ? r_mem[address_a] : '0;
    assign w_rd_b = w_b_in_range ? r_mem[address_b] : '0;

    generate
        if (latency == 0) begin : g_lat0
            logic w_unused_ctrl;
            assign w_unused_ctrl = clken ^ reset;
            assign q_a = w_rd_a;
            assign q_b = w_rd_b;
        end else begin : g_lat_reg
            logic [width_a-1:0] r_q1_a;
            logic [width_b-1:0] r_q1_b;

            // Sampled from the array before this edge's write lands: read-first.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_q1_a <= '0;
                    r_q1_b <= '0;
                end else if (clken) begin
                    r_q1_a <= w_rd_a;
                    r_q1_b <= w_rd_b;
                end
            end

            if (latency == 2) begin : g_lat2
                logic [width_a-1:0] r_q2_a;
                logic [width_b-1:0] r_q2_b;

                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        r_q2_a <= '0;
                        r_q2_b <= '0;
                    end else if (clken) begin
                        r_q2_a <= r_q1_a;
                        r_q2_b <= r_q1_b;
                    end
                end

                assign q_a = r_q2_a;
                assign q_b = r_q2_b;
            end else begin : g_lat1
                assign q_a = r_q1_a;
                assign q_b = r_q1_b;
            end
        end
    endgenerate

`ifdef TEXTURE_MAPPER_RAM_COLLISION_CHECK_EN
    // Simulation-only: never part of the synthesised netlist.
    initial begin
        if ((width_a != width_b) || (widthad_a != widthad_b) || (numwords_a != numwords_b) ||
            (numwords_a < 1) || (numwords_a > (1 << widthad_a)) || (latency < 0) || (latency > 2)) begin
            $fatal(1, "Error: illegal texture_mapper_dual_port_fifo_ram parameters");
        end
    end

    always @(posedge clk) begin
        if (clken && wren_a && wren_b && (address_a == address_b)) begin
            $display("Error: dual-port write collision at address %0d", address_a);
            $finish;
        end
    end
`endif

endmodule

// File: tb/tb_texture_mapper_dual_port_fifo_ram.sv
// Randomised + directed bench for texture_mapper_dual_port_fifo_ram at latency 0 (12 words), 1 and 2.
module tb_texture_mapper_dual_port_fifo_ram;

    logic        clk = 1'b0;
    logic        reset;
    logic        clken;
    logic [3:0]  address_a;
    logic [3:0]  address_b;
    logic        wren_a;
    logic        wren_b;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic [31:0] q0a, q0b, q1a, q1b, q2a, q2b;

    int n_vec = 0;
    int n_err = 0;
    bit init_done = 1'b0;

    // Reference: a plain word array plus the expected value of each output stage.
    logic [31:0] m_mem [16];
    logic [31:0] e1a = '0, e1b = '0, e2a = '0, e2b = '0;

    always #5 clk = ~clk;

    texture_mapper_dual_port_fifo_ram #(.latency(0), .numwords_a(12), .numwords_b(12)) u_l0 (
        .clk(clk), .reset(reset), .clken(clken),
        .address_a(address_a), .wren_a(wren_a), .data_a(data_a), .q_a(q0a),
        .address_b(address_b), .wren_b(wren_b), .data_b(data_b), .q_b(q0b));

    texture_mapper_dual_port_fifo_ram u_l1 (
        .clk(clk), .reset(reset), .clken(clken),
        .address_a(address_a), .wren_a(wren_a), .data_a(data_a), .q_a(q1a),
        .address_b(address_b), .wren_b(wren_b), .data_b(data_b), .q_b(q1b));

    texture_mapper_dual_port_fifo_ram #(.latency(2)) u_l2 (
        .clk(clk), .reset(reset), .clken(clken),
        .address_a(address_a), .wren_a(wren_a), .data_a(data_a), .q_a(q2a),
        .address_b(address_b), .wren_b(wren_b), .data_b(data_b), .q_b(q2b));

    function automatic logic [31:0] m_rd(input logic [3:0] a, input int n);
        if (int'(a) < n) return m_mem[a];
        return 32'h0;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        logic [31:0] ra, rb;
        ra = m_rd(address_a, 16);
        rb = m_rd(address_b, 16);
        if (clken) begin
            if (reset) begin
                e2a = e1a;
                e2b = e1b;
                e1a = ra;
                e1b = rb;
            end
            if (wren_b) m_mem[address_b] = data_b;
            if (wren_a) m_mem[address_a] = data_a;
        end
    end

    always @(negedge reset) begin
        e1a = '0;
        e1b = '0;
        e2a = '0;
        e2b = '0;
    end

    always @(negedge clk) begin
        check("l1_qa", q1a, e1a);
        check("l1_qb", q1b, e1b);
        check("l2_qa", q2a, e2a);
        check("l2_qb", q2b, e2b);
        if (init_done) begin
            check("l0_qa", q0a, m_rd(address_a, 12));
            check("l0_qb", q0b, m_rd(address_b, 12));
        end
    end

    initial begin
        reset = 1'b1; clken = 1'b1; wren_a = 1'b0; wren_b = 1'b0;
        address_a = '0; address_b = '0; data_a = '0; data_b = '0;
        #2 reset = 1'b0;
        #1;
        check("rst_l1_qb", q1b, 32'h0);
        check("rst_l2_qa", q2a, 32'h0);

        // Fill every word while reset is held: writes still land, outputs stay 0.
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) begin
                wren_a = 1'b1; wren_b = 1'b0; address_a = 4'(i); data_a = $urandom;
            end else begin
                wren_a = 1'b0; wren_b = 1'b1; address_b = 4'(i); data_b = $urandom;
            end
            tick();
            check("init_rst_q1a", q1a, 32'h0);
        end
        wren_a = 1'b0; wren_b = 1'b0; address_b = '0;
        init_done = 1'b1;
        reset = 1'b1;
        tick();

        // Asynchronous clear mid-cycle, no clock edge needed.
        tick();
        #2 reset = 1'b0;
        #1;
        check("async_rst_q1b", q1b, 32'h0);
        check("async_rst_q2b", q2b, 32'h0);
        tick();
        reset = 1'b1;

        // Write via A, read via B next cycle.
        wren_a = 1'b1; address_a = 4'd3; data_a = 32'hDEADBEEF; address_b = 4'd0;
        tick();
        wren_a = 1'b0; address_b = 4'd3;
        tick();
        check("wr_rd_q1b", q1b, 32'hDEADBEEF);

        // Read-first on a same-cycle write/read of one address.
        wren_a = 1'b1; address_a = 4'd5; data_a = 32'h22;
        tick();
        data_a = 32'h11; address_b = 4'd5;
        tick();
        check("rdfirst_old", q1b, 32'h22);
        wren_a = 1'b0;
        tick();
        check("rdfirst_new", q1b, 32'h11);

        // Latency 0: visible right after the edge; reset has no effect.
        wren_a = 1'b1; address_a = 4'd7; data_a = 32'hA5A5; address_b = 4'd7;
        tick();
        wren_a = 1'b0;
        check("lat0_q0b", q0b, 32'hA5A5);
        reset = 1'b0;
        #1 check("lat0_rst_q0b", q0b, 32'hA5A5);
        reset = 1'b1;
        #1 check("lat0_rel_q0b", q0b, 32'hA5A5);

        // clken=0 blocks the write and freezes the output registers.
        wren_a = 1'b1; address_a = 4'd2; data_a = 32'h77;
        tick();
        wren_a = 1'b0; address_b = 4'd2;
        tick();
        check("hold_pre", q1b, 32'h77);
        clken = 1'b0; wren_a = 1'b1; data_a = 32'h99;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_q1b", q1b, 32'h77);
        end
        clken = 1'b1; wren_a = 1'b0;
        tick();
        check("hold_mem", q1b, 32'h77);

        // Both ports write one address: A wins.
        wren_a = 1'b1; wren_b = 1'b1; address_a = 4'd9; address_b = 4'd9;
        data_a = 32'h1; data_b = 32'h2;
        tick();
        wren_a = 1'b0; wren_b = 1'b0;
        tick();
        check("collide_q1b", q1b, 32'h1);

        // Sequential fill with a reset pulse in the middle, then ordered readback.
        for (int i = 0; i < 16; i++) begin
            wren_a = 1'b1; address_a = 4'(i); data_a = 32'hC000_0000 + 32'(i * 3);
            if (i == 8) reset = 1'b0;
            if (i == 10) reset = 1'b1;
            tick();
        end
        wren_a = 1'b0;
        for (int i = 0; i < 16; i++) begin
            address_b = 4'(i);
            tick();
            check("seq_q1b", q1b, 32'hC000_0000 + 32'(i * 3));
            if (i > 0) check("seq_q2b", q2b, 32'hC000_0000 + 32'((i - 1) * 3));
            check("seq_q0b", q0b, (i < 12) ? 32'hC000_0000 + 32'(i * 3) : 32'h0);
        end

        // Random traffic against the reference.
        for (int k = 0; k < 400; k++) begin
            address_a = 4'($urandom_range(0, 15));
            address_b = 4'($urandom_range(0, 15));
            wren_a = ($urandom_range(0, 2) == 0);
            wren_b = ($urandom_range(0, 2) == 0);
            data_a = $urandom;
            data_b = $urandom;
            clken = ($urandom_range(0, 9) != 0);
            reset = ($urandom_range(0, 29) != 0);
            tick();
        end
        reset = 1'b1; clken = 1'b1; wren_a = 1'b0; wren_b = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
